// File: rtl/chunked_adder_if.sv
// Operand/result handshake bundle for chunked_adder.
// The optional sub line exists only when CHUNKED_ADDER_SUB_EN is defined.
interface chunked_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CHUNKED_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
`ifdef CHUNKED_ADDER_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
`ifdef CHUNKED_ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle adder: WIDTH-bit a + b + cin, CHUNK bits per clock through a registered carry.
// Optional subtract mode is compiled in with CHUNKED_ADDER_SUB_EN.
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic            clk,
  input logic            rst_n,
  chunked_adder_if.slave bus
);
  localparam int NCH  = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCH - 1);

  generate
    if (CHUNK <= 0 || (WIDTH % ((CHUNK > 0) ? CHUNK : 1)) != 0) begin : g_bad_params
      $error("chunked_adder: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             carry_reg, carry_next;
  logic [IDXW-1:0]  idx_reg, idx_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;

  logic [CHUNK-1:0] a_chunk [NCH];
  logic [CHUNK-1:0] b_chunk [NCH];
  logic [CHUNK-1:0] a_cur, b_cur, s_cur;
  logic             c_cur;
  logic             msb_carry;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
      assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
      // Only the slice under the current index is written; the rest hold.
      assign sum_next[gi*CHUNK +: CHUNK] =
          (state_reg == CALC && idx_reg == IDXW'(gi)) ? s_cur : sum_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign a_cur = a_chunk[idx_reg];
  assign b_cur = b_chunk[idx_reg];
  assign {c_cur, s_cur} = {1'b0, a_cur} + {1'b0, b_cur} + {{CHUNK{1'b0}}, carry_reg};
  // Carry into the MSB recovered from the MSB's own sum bit (only meaningful on the last chunk).
  assign msb_carry = a_cur[CHUNK-1] ^ b_cur[CHUNK-1] ^ s_cur[CHUNK-1];

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    carry_next = carry_reg;
    idx_next   = idx_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          a_next     = bus.a;
`ifdef CHUNKED_ADDER_SUB_EN
          b_next     = bus.sub ? ~bus.b : bus.b;
          carry_next = bus.sub | bus.cin;
`else
          b_next     = bus.b;
          carry_next = bus.cin;
`endif
          idx_next   = '0;
          state_next = CALC;
        end
      end
      CALC: begin
        carry_next = c_cur;
        idx_next   = idx_reg + IDXW'(1);
        if (idx_reg == LAST) begin
          cout_next  = c_cur;
          ovf_next   = c_cur ^ msb_carry;
          idx_next   = '0;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      carry_reg <= carry_next;
      idx_reg   <= idx_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder: 16/4 instance for directed and random ops,
// 1/1 instance for the exhaustive full-adder case.
module tb_chunked_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst1_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  chunked_adder_if #(.WIDTH(16)) bus ();
  chunked_adder_if #(.WIDTH(1))  bus1 ();

  chunked_adder #(.WIDTH(16), .CHUNK(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  chunked_adder #(.WIDTH(1),  .CHUNK(1)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(bus1.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the full operands.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    int ua, ub, us, sa, sb, ss;
    logic c, o;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    if (sub) begin
      us = ua - ub;
      ss = sa - sb;
      c  = (ua >= ub);
    end else begin
      us = ua + ub + int'(cin);
      ss = sa + sb + int'(cin);
      c  = (us >= 65536);
    end
    o = (ss > 32767) || (ss < -32768);
    return {o, c, us[15:0]};
  endfunction

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub);
    check("in_ready_idle", bus.in_ready, 1);
    bus.a = a; bus.b = b; bus.cin = cin;
`ifdef CHUNKED_ADDER_SUB_EN
    bus.sub = sub;
`endif
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
`ifdef CHUNKED_ADDER_SUB_EN
    bus.sub = 1'($urandom);
`endif
    check("in_ready_busy", bus.in_ready, 0);
    if (sub == 1'b0) begin end
  endtask

  task automatic await_result(input logic [15:0] a, input logic [15:0] b, input logic cin,
                              input logic sub, input int hold);
    logic [17:0] exp;
    int cycles;
    exp = model(a, b, cin, sub);
    cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    check("latency", cycles, 4);
    check("sum", bus.sum, exp[15:0]);
    check("cout", bus.cout, exp[16]);
    check("ovf", bus.ovf, exp[17]);
    $display("op a=%h b=%h cin=%0b sub=%0b -> sum=%h cout=%0b ovf=%0b",
             a, b, cin, sub, bus.sum, bus.cout, bus.ovf);
    for (int k = 0; k < hold; k++) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("out_valid_drop", bus.out_valid, 0);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub);
    launch(a, b, cin, sub);
    await_result(a, b, cin, sub, int'($urandom_range(0, 2)));
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic rc, rs;
    logic [15:0] held;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
`ifdef CHUNKED_ADDER_SUB_EN
    bus.sub = 1'b0; bus1.sub = 1'b0;
`endif
    tick(); tick();
    rst_n = 1'b1; rst1_n = 1'b1;
    tick();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_ovf", bus.ovf, 0);

    do_op(16'h1234, 16'h1111, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);

    // Consumer stalls in DONE while producer pokes in_valid.
    launch(16'hABCD, 16'h1357, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    check("stall_valid", bus.out_valid, 1);
    held = bus.sum;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'(k % 2);
      bus.a = 16'($urandom); bus.b = 16'($urandom);
      tick();
      check("stall_valid_hold", bus.out_valid, 1);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_sum_hold", bus.sum, held);
    end
    bus.in_valid = 1'b0;
    check("stall_sum", bus.sum, model(16'hABCD, 16'h1357, 1'b1, 1'b0) & 18'hFFFF);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("stall_release_ready", bus.in_ready, 1);
    check("stall_release_valid", bus.out_valid, 0);
    tick();
    check("no_ghost_op", bus.out_valid, 0);

    // Reset in the middle of CALC.
    launch(16'h5555, 16'hAAAA, 1'b1, 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_sum", bus.sum, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("midrst_no_result", bus.out_valid, 0);
    end
    do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
`ifdef CHUNKED_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      do_op(ra, rb, rc, rs);
    end

`ifdef CHUNKED_ADDER_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    do_op(16'h8000, 16'h0001, 1'b1, 1'b1);
    do_op(16'h1234, 16'h1234, 1'b0, 1'b1);
`endif

    // Exhaustive 1-bit full adder.
    for (int v = 0; v < 8; v++) begin
      int cycles;
      logic [2:0] bits;
      bits = 3'(v);
      check("fa_in_ready", bus1.in_ready, 1);
      bus1.a = bits[2]; bus1.b = bits[1]; bus1.cin = bits[0];
      bus1.in_valid = 1'b1;
      tick();
      bus1.in_valid = 1'b0;
      cycles = 0;
      while (!bus1.out_valid && cycles < 10) begin
        tick();
        cycles++;
      end
      check("fa_latency", cycles, 1);
      check("fa_result", {bus1.cout, bus1.sum},
            32'(int'(bits[2]) + int'(bits[1]) + int'(bits[0])));
      $display("fa a=%0b b=%0b cin=%0b -> cout=%0b sum=%0b",
               bits[2], bits[1], bits[0], bus1.cout, bus1.sum);
      bus1.out_ready = 1'b1;
      tick();
      bus1.out_ready = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
